dphy_hs_lane_seq: RTL and testbench
===================================

// Module: dphy_hs_lane_seq
// PURPOSE
//  Per-lane D-PHY receive sequencer. Tracks LP line states and walks the LP-11 -> LP-01 -> LP-00 start-of-transmission handshake.
//  Enables HS termination and the deserializer/aligner, waits T_HS-SETTLE, then gates aligned HS bytes to the packet layer until the lane returns to LP-11.
//  Sits between the lane PHY primitives/byte aligner and the CSI-2 lane merger; gated by the clock-lane presence reset.
// PARAMETERS
//  SETTLE_CYCLES  8   byte_clk cycles with termination on and HS capture off (0 treated as 1)
//  SYNC_TIMEOUT   32  byte_clk cycles allowed in SYNC_WAIT before a SoT sync error
//  CNT_W          8   shared counter width; must hold max(SETTLE_CYCLES, SYNC_TIMEOUT)
// PORTS
//  byte_clk_i     in   1  byte clock; all logic in this domain
//  rst_i          in   1  reset, asynchronous, active-high
//  enable_i       in   1  lane enable from CSR
//  phy_rdy_i      in   1  1 = clock lane present (inverse of clock-detect reset)
//  lp_p_i, lp_n_i in   1  LP receiver outputs, already synchronized to byte_clk_i
//  hs_byte_i      in   8  word-aligned HS byte from aligner
//  sync_det_i     in   1  aligner: hs_byte_i this cycle is the 0xB8 sync byte
//  term_en_o      out  1  HS termination enable
//  hs_rx_en_o     out  1  deserializer/aligner enable (aligner held in reset when 0)
//  byte_o         out  8  payload byte
//  byte_valid_o   out  1  byte_o valid
//  sot_o          out  1  1-cycle pulse: sync found, payload starts next cycle
//  eot_o          out  1  1-cycle pulse: LP-11 seen in HS_RX
//  err_sync_o     out  1  1-cycle pulse: sync timeout, or LP-11 in SYNC_WAIT
//  err_ctrl_o     out  1  1-cycle pulse: illegal LP sequence (LP-10 in HS_RQST)
//  state_o        out  3  current state encoding (debug)
// BEHAVIOUR
//  Reset: state DISABLED (0), counter 0, all outputs 0. Asserts immediately; FSM runs the cycle after deassert.
//  All outputs are registered; state_o = current state.
//  States: DISABLED=0, STOP=1, HS_RQST=2, SETTLE=3, SYNC_WAIT=4, HS_RX=5, ERR_WAIT=6.
//  Priority, highest first: (!enable_i || !phy_rdy_i) -> DISABLED from any state, with no eot/err pulse; then LP-11 exit; then other transitions.
//  LP code = {lp_p_i, lp_n_i}.
//  DISABLED: leave to STOP when enabled, ready and LP=11; otherwise stay.
//  STOP: LP=01 -> HS_RQST; any other code stays.
//  HS_RQST: LP=00 -> SETTLE; LP=11 -> STOP (abort, no error); LP=10 -> ERR_WAIT with err_ctrl_o; LP=01 stays.
//  SETTLE: term_en_o=1, hs_rx_en_o=0. LP inputs ignored. Counter cleared on entry.
//    Exit to SYNC_WAIT after exactly SETTLE_CYCLES cycles in state.
//  SYNC_WAIT: term_en_o=1, hs_rx_en_o=1. Counter cleared on entry.
//    sync_det_i -> HS_RX with sot_o.
//    Counter reaches SYNC_TIMEOUT -> ERR_WAIT with err_sync_o.
//    LP=11 -> STOP with err_sync_o.
//    LP=11 and sync_det_i in the same cycle: LP-11 wins.
//  HS_RX: term_en_o=1, hs_rx_en_o=1.
//    Each cycle: byte_o <= hs_byte_i, byte_valid_o <= 1; latency 1 cycle.
//    The sync byte itself is never forwarded.
//    LP=11 -> STOP with eot_o; the byte in that cycle is dropped (byte_valid_o=0).
//    EoT trailer trimming is downstream's job.
//    sync_det_i is ignored in HS_RX.
//  ERR_WAIT: all enables 0; LP=11 -> STOP.
//  Outside HS_RX: byte_valid_o=0; byte_o holds its last value.
//  term_en_o and hs_rx_en_o follow the registered next state, so they change in the same cycle as state_o.
//  Counter saturates at its terminal value and never wraps.
// TESTING
//  1 Nominal: LP 11,01,00; 8 settle cycles; sync_det with B8; bytes 11,22,33; then LP 11.
//    -> term_en_o rises with SETTLE; hs_rx_en_o rises 8 cycles later; sot_o once.
//    -> byte_o 11,22,33 valid on consecutive cycles; eot_o once; state back to STOP.
//  2 Timeout: as 1 but no sync_det_i -> err_sync_o pulses 32 cycles after SYNC_WAIT entry.
//    -> state ERR_WAIT, term_en_o=0; STOP only after LP 11.
//  3 Aborted request: LP 11,01,11 -> back to STOP; term_en_o never asserts; no error pulses.
//  4 Illegal: LP 11,01,10 -> err_ctrl_o one pulse; ERR_WAIT; LP 00 ignored; LP 11 -> STOP.
//  5 Clock loss: phy_rdy_i low mid HS_RX (byte 0x5A) -> next cycle state DISABLED.
//    -> byte_valid_o=0, term_en_o=0, no eot_o; re-entry requires LP 11.
//  6 Async reset mid SETTLE, plus sync_det_i together with LP 11 in SYNC_WAIT.
//    -> reset: outputs 0 without a clock edge.
//    -> collision: STOP with err_sync_o, no sot_o.

Source files
------------

// File: rtl/dphy_hs_lane_seq_if.sv
// Lane-side signal bundle for the D-PHY HS lane sequencer: LP line states and aligner
// inputs toward the sequencer, HS enables, payload bytes and status pulses back out.
interface dphy_hs_lane_seq_if;
    logic       enable;
    logic       phy_rdy;
    logic       lp_p;
    logic       lp_n;
    logic [7:0] hs_byte;
    logic       sync_det;

    logic       term_en;
    logic       hs_rx_en;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       sot;
    logic       eot;
    logic       err_sync;
    logic       err_ctrl;
    logic [2:0] state;

    // Master drives the lane; slave is the sequencer itself.
    modport master (
        output enable, phy_rdy, lp_p, lp_n, hs_byte, sync_det,
        input  term_en, hs_rx_en, byte_data, byte_valid, sot, eot, err_sync, err_ctrl, state
    );

    modport slave (
        input  enable, phy_rdy, lp_p, lp_n, hs_byte, sync_det,
        output term_en, hs_rx_en, byte_data, byte_valid, sot, eot, err_sync, err_ctrl, state
    );
endinterface

// File: rtl/dphy_hs_lane_seq.sv
// Per-lane D-PHY receive sequencer: walks the LP-11/01/00 SoT handshake, settles the HS
// termination, hunts for the sync byte and gates aligned HS bytes until the lane returns to LP-11.
module dphy_hs_lane_seq #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SYNC_TIMEOUT  = 32,
    parameter int unsigned CNT_W         = 8
) (
    input  logic              byte_clk_i,
    input  logic              rst_i,
    dphy_hs_lane_seq_if.slave lane
);
    typedef enum logic [2:0] {
        ST_DISABLED  = 3'd0,
        ST_STOP      = 3'd1,
        ST_HS_RQST   = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_SYNC_WAIT = 3'd4,
        ST_HS_RX     = 3'd5,
        ST_ERR_WAIT  = 3'd6
    } state_t;

    localparam logic [1:0] LP_00 = 2'b00;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_10 = 2'b10;
    localparam logic [1:0] LP_11 = 2'b11;

    localparam int unsigned    SETTLE_EFF   = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned    TIMEOUT_EFF  = (SYNC_TIMEOUT == 0) ? 1 : SYNC_TIMEOUT;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_EFF - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [1:0]       lp_code;
    logic [7:0]       byte_q, byte_nxt;
    logic             valid_nxt, sot_nxt, eot_nxt, err_sync_nxt, err_ctrl_nxt;
    logic             term_en_q, hs_rx_en_q, valid_q, sot_q, eot_q, err_sync_q, err_ctrl_q;

    assign lp_code = {lane.lp_p, lane.lp_n};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_nxt    = state_q;
        sot_nxt      = 1'b0;
        eot_nxt      = 1'b0;
        err_sync_nxt = 1'b0;
        err_ctrl_nxt = 1'b0;

        if (!lane.enable || !lane.phy_rdy) begin
            state_nxt = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: if (lp_code == LP_11) state_nxt = ST_STOP;
                ST_STOP:     if (lp_code == LP_01) state_nxt = ST_HS_RQST;
                ST_HS_RQST: begin
                    case (lp_code)
                        LP_00: state_nxt = ST_SETTLE;
                        LP_11: state_nxt = ST_STOP;
                        LP_10: begin
                            state_nxt    = ST_ERR_WAIT;
                            err_ctrl_nxt = 1'b1;
                        end
                        default: state_nxt = ST_HS_RQST;
                    endcase
                end
                // LP lines are not trusted while the termination settles.
                ST_SETTLE: if (cnt_q == SETTLE_LAST) state_nxt = ST_SYNC_WAIT;
                ST_SYNC_WAIT: begin
                    if (lp_code == LP_11) begin
                        state_nxt    = ST_STOP;
                        err_sync_nxt = 1'b1;
                    end else if (lane.sync_det) begin
                        state_nxt = ST_HS_RX;
                        sot_nxt   = 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_nxt    = ST_ERR_WAIT;
                        err_sync_nxt = 1'b1;
                    end
                end
                ST_HS_RX: begin
                    if (lp_code == LP_11) begin
                        state_nxt = ST_STOP;
                        eot_nxt   = 1'b1;
                    end
                end
                ST_ERR_WAIT: if (lp_code == LP_11) state_nxt = ST_STOP;
                default:     state_nxt = ST_DISABLED;
            endcase
        end

        // The counter restarts on every state change and saturates rather than wrapping.
        if (state_nxt != state_q) begin
            cnt_nxt = '0;
        end else if ((state_q == ST_SETTLE || state_q == ST_SYNC_WAIT) && cnt_q != CNT_MAX) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end else begin
            cnt_nxt = cnt_q;
        end

        // Only bytes seen while staying in HS_RX are payload; the sync byte and the EoT cycle are not.
        valid_nxt = (state_q == ST_HS_RX) && (state_nxt == ST_HS_RX);
        byte_nxt  = valid_nxt ? lane.hs_byte : byte_q;
    end

    always_ff @(posedge byte_clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
        if (rst_i) begin
            state_q    <= ST_DISABLED;
            cnt_q      <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            term_en_q  <= 1'b0;
            hs_rx_en_q <= 1'b0;
            sot_q      <= 1'b0;
            eot_q      <= 1'b0;
            err_sync_q <= 1'b0;
            err_ctrl_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            byte_q     <= byte_nxt;
            valid_q    <= valid_nxt;
            term_en_q  <= (state_nxt == ST_SETTLE) || (state_nxt == ST_SYNC_WAIT) ||
                          (state_nxt == ST_HS_RX);
            hs_rx_en_q <= (state_nxt == ST_SYNC_WAIT) || (state_nxt == ST_HS_RX);
            sot_q      <= sot_nxt;
            eot_q      <= eot_nxt;
            err_sync_q <= err_sync_nxt;
            err_ctrl_q <= err_ctrl_nxt;
        end
    end

    assign lane.state      = state_q;
    assign lane.term_en    = term_en_q;
    assign lane.hs_rx_en   = hs_rx_en_q;
    assign lane.byte_data  = byte_q;
    assign lane.byte_valid = valid_q;
    assign lane.sot        = sot_q;
    assign lane.eot        = eot_q;
    assign lane.err_sync   = err_sync_q;
    assign lane.err_ctrl   = err_ctrl_q;
endmodule

// File: tb/tb_dphy_hs_lane_seq.sv
// Bench for dphy_hs_lane_seq: directed SoT/EoT/error scenarios followed by a randomized lane walk,
// every cycle compared against a phase/dwell reference model of the lane protocol.
module tb_dphy_hs_lane_seq;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 32;

    logic byte_clk = 1'b0;
    logic rst      = 1'b1;

    dphy_hs_lane_seq_if lane ();

    dphy_hs_lane_seq #(
        .SETTLE_CYCLES(SETTLE),
        .SYNC_TIMEOUT (TIMEOUT),
        .CNT_W        (8)
    ) dut (
        .byte_clk_i(byte_clk),
        .rst_i     (rst),
        .lane      (lane)
    );

    always #5 byte_clk = ~byte_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Protocol phases of the lane as seen from the line, with time spent in each.
    typedef enum int {P_OFF, P_IDLE, P_REQ, P_SETTLE, P_HUNT, P_DATA, P_FAULT} phase_t;

    phase_t     m_phase;
    int         m_dwell;
    logic [7:0] m_byte;
    bit         m_valid, m_sot, m_eot, m_es, m_ec;

    function automatic logic [2:0] phase_code(input phase_t p);
        case (p)
            P_OFF:    return 3'd0;
            P_IDLE:   return 3'd1;
            P_REQ:    return 3'd2;
            P_SETTLE: return 3'd3;
            P_HUNT:   return 3'd4;
            P_DATA:   return 3'd5;
            default:  return 3'd6;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = P_OFF;
        m_dwell = 0;
        m_byte  = 8'h00;
        {m_valid, m_sot, m_eot, m_es, m_ec} = '0;
    endtask

    // What the lane should report after one byte clock with the given line conditions.
    task automatic model_step(input bit en, input bit rdy, input bit [1:0] lp,
                              input bit [7:0] hb, input bit sd);
        phase_t nxt;
        bit     lp11;
        nxt  = m_phase;
        lp11 = (lp == 2'b11);
        {m_valid, m_sot, m_eot, m_es, m_ec} = '0;
        m_dwell++;
        if (!(en && rdy)) begin
            nxt = P_OFF;
        end else begin
            case (m_phase)
                P_OFF:  if (lp11) nxt = P_IDLE;
                P_IDLE: if (lp == 2'b01) nxt = P_REQ;
                P_REQ: begin
                    if (lp == 2'b00) nxt = P_SETTLE;
                    else if (lp11) nxt = P_IDLE;
                    else if (lp == 2'b10) begin
                        nxt  = P_FAULT;
                        m_ec = 1'b1;
                    end
                end
                P_SETTLE: if (m_dwell >= SETTLE) nxt = P_HUNT;
                P_HUNT: begin
                    if (lp11) begin
                        nxt  = P_IDLE;
                        m_es = 1'b1;
                    end else if (sd) begin
                        nxt   = P_DATA;
                        m_sot = 1'b1;
                    end else if (m_dwell >= TIMEOUT) begin
                        nxt  = P_FAULT;
                        m_es = 1'b1;
                    end
                end
                P_DATA: begin
                    if (lp11) begin
                        nxt   = P_IDLE;
                        m_eot = 1'b1;
                    end else begin
                        m_valid = 1'b1;
                        m_byte  = hb;
                    end
                end
                default: if (lp11) nxt = P_IDLE;
            endcase
        end
        if (nxt != m_phase) m_dwell = 0;
        m_phase = nxt;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic compare_outputs(input string tag);
        logic [9:0] got, exp;
        bit         term, hsrx;
        term = (m_phase == P_SETTLE) || (m_phase == P_HUNT) || (m_phase == P_DATA);
        hsrx = (m_phase == P_HUNT) || (m_phase == P_DATA);
        got  = {lane.state, lane.term_en, lane.hs_rx_en, lane.byte_valid,
                lane.sot, lane.eot, lane.err_sync, lane.err_ctrl};
        exp  = {phase_code(m_phase), term, hsrx, m_valid, m_sot, m_eot, m_es, m_ec};
        check({tag, ".ctl"}, 32'(got), 32'(exp));
        check({tag, ".byte"}, 32'(lane.byte_data), 32'(m_byte));
    endtask

    // Drive one cycle of line state just after a falling edge, then compare after the next one.
    task automatic tick(input string tag, input bit en, input bit rdy, input bit [1:0] lp,
                        input bit [7:0] hb, input bit sd);
        lane.enable   = en;
        lane.phy_rdy  = rdy;
        lane.lp_p     = lp[1];
        lane.lp_n     = lp[0];
        lane.hs_byte  = hb;
        lane.sync_det = sd;
        model_step(en, rdy, lp, hb, sd);
        @(posedge byte_clk);
        @(negedge byte_clk);
        compare_outputs(tag);
    endtask

    task automatic lead_in(input string tag);
        tick(tag, 1, 1, 2'b11, 8'h00, 0);
        tick(tag, 1, 1, 2'b11, 8'h00, 0);
        tick(tag, 1, 1, 2'b01, 8'h00, 0);
        tick(tag, 1, 1, 2'b00, 8'h00, 0);
        for (int i = 0; i < SETTLE; i++) tick(tag, 1, 1, 2'b00, 8'($urandom), 0);
    endtask

    initial begin
        lane.enable   = 1'b0;
        lane.phy_rdy  = 1'b0;
        lane.lp_p     = 1'b1;
        lane.lp_n     = 1'b1;
        lane.hs_byte  = 8'h00;
        lane.sync_det = 1'b0;
        model_reset();

        #2;
        compare_outputs("reset");
        @(negedge byte_clk);
        rst = 1'b0;

        // Nominal SoT, three payload bytes, EoT.
        lead_in("nominal");
        tick("nominal", 1, 1, 2'b00, 8'hB8, 1);
        tick("nominal", 1, 1, 2'b00, 8'h11, 0);
        tick("nominal", 1, 1, 2'b00, 8'h22, 1);
        tick("nominal", 1, 1, 2'b00, 8'h33, 0);
        tick("nominal", 1, 1, 2'b11, 8'h44, 0);
        tick("nominal", 1, 1, 2'b11, 8'h55, 0);

        // Sync never arrives.
        lead_in("timeout");
        for (int i = 0; i < TIMEOUT + 1; i++) tick("timeout", 1, 1, 2'b00, 8'h00, 0);
        tick("timeout", 1, 1, 2'b00, 8'h00, 1);
        tick("timeout", 1, 1, 2'b11, 8'h00, 0);

        // Request aborted back to stop.
        tick("abort", 1, 1, 2'b11, 8'h00, 0);
        tick("abort", 1, 1, 2'b01, 8'h00, 0);
        tick("abort", 1, 1, 2'b11, 8'h00, 0);
        tick("abort", 1, 1, 2'b11, 8'h00, 0);

        // Illegal LP-10 during the request.
        tick("illegal", 1, 1, 2'b01, 8'h00, 0);
        tick("illegal", 1, 1, 2'b10, 8'h00, 0);
        tick("illegal", 1, 1, 2'b00, 8'h00, 0);
        tick("illegal", 1, 1, 2'b11, 8'h00, 0);

        // Clock lane disappears mid-packet.
        lead_in("clkloss");
        tick("clkloss", 1, 1, 2'b00, 8'hB8, 1);
        tick("clkloss", 1, 1, 2'b00, 8'hA7, 0);
        tick("clkloss", 1, 0, 2'b00, 8'h5A, 0);
        tick("clkloss", 1, 1, 2'b00, 8'h00, 0);
        tick("clkloss", 1, 1, 2'b11, 8'h00, 0);

        // Asynchronous reset in the middle of SETTLE, observed before any clock edge.
        tick("rst_mid", 1, 1, 2'b01, 8'h00, 0);
        tick("rst_mid", 1, 1, 2'b00, 8'h00, 0);
        tick("rst_mid", 1, 1, 2'b00, 8'h00, 0);
        tick("rst_mid", 1, 1, 2'b00, 8'h00, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs("rst_async");
        @(negedge byte_clk);
        rst = 1'b0;

        // Sync and LP-11 in the same SYNC_WAIT cycle: the line wins.
        lead_in("collide");
        tick("collide", 1, 1, 2'b11, 8'hB8, 1);
        tick("collide", 1, 1, 2'b11, 8'h00, 0);

        // Randomized walk steered loosely by the model's phase so every phase gets traffic.
        for (int n = 0; n < 3000; n++) begin
            bit [1:0] lp;
            bit       en, rdy, sd;
            int       r;
            r   = int'($urandom_range(0, 9));
            en  = ($urandom_range(0, 59) != 0);
            rdy = ($urandom_range(0, 59) != 0);
            sd  = ($urandom_range(0, 7) == 0);
            lp  = 2'($urandom);
            case (m_phase)
                P_OFF:    if (r < 7) lp = 2'b11;
                P_IDLE:   if (r < 5) lp = 2'b01;
                P_REQ:    if (r < 6) lp = 2'b00;
                P_SETTLE: if (r < 7) lp = 2'b00;
                P_HUNT: begin
                    lp = (r == 0) ? 2'b11 : 2'b00;
                    sd = ($urandom_range(0, 19) == 0);
                end
                P_DATA:   lp = (r == 0) ? 2'b11 : 2'b00;
                default:  if (r < 3) lp = 2'b11;
            endcase
            tick("random", en, rdy, lp, 8'($urandom), sd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
